// File: rtl/seq_shift_pkg.sv
// ============================================================================
// Module   : seq_shift_pkg
// Purpose  : Mode encodings shared by the programmable sequence shifter
//            and its benches.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package seq_shift_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_HOLD = 3'b000;
    localparam mode_t MODE_SHR  = 3'b001;
    localparam mode_t MODE_SHL  = 3'b010;
    localparam mode_t MODE_LOAD = 3'b011;
    localparam mode_t MODE_ROTL = 3'b100;
    localparam mode_t MODE_ROTR = 3'b101;
    localparam mode_t MODE_LFSR = 3'b110;
    localparam mode_t MODE_ASR  = 3'b111;

endpackage

`default_nettype wire

// File: rtl/prog_seq_shifter_seq_len_mask.sv
// ============================================================================
// Module   : seq_len_mask
// Purpose  : Expands an active length L into a WIDTH-bit mask with bits
//            [L-1:0] set.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_len_mask #(
    parameter int WIDTH = 8,
    parameter int LEN_W = $clog2(WIDTH) + 1
) (
    input  logic [LEN_W-1:0] len,
    output logic [WIDTH-1:0] mask
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_mask_bit
        assign mask[i] = (32'(len) > 32'(i));
    end

endmodule

`default_nettype wire

// File: rtl/prog_seq_shifter.sv
// ============================================================================
// Module   : prog_seq_shifter
// Purpose  : Programmable-length shift/rotate/LFSR register with period
//            counter and wrap pulse. Define SEQ_SHIFTER_LFSR_EN to build the
//            LFSR mode; otherwise mode 110 holds without counting.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module prog_seq_shifter
    import seq_shift_pkg::*;
#(
    parameter int              WIDTH = 8,
    parameter int              LEN_W = $clog2(WIDTH) + 1,
    parameter logic [WIDTH-1:0] TAPS = WIDTH'(8'hB8)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] seq_len,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic [LEN_W-1:0] cnt,
    output logic             wrap
);

    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] len_load;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] top_bit;
    logic [WIDTH-1:0] q_next;
    logic             advance;

    seq_len_mask #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_mask (
        .len  (len_r),
        .mask (mask)
    );

    // Highest set bit of the mask marks position L-1.
    assign top_bit = mask & ~(mask >> 1);
    assign ser_out = |(q & top_bit);

    assign len_load = ((seq_len == '0) || (32'(seq_len) > WIDTH)) ? LEN_W'(WIDTH) : seq_len;

`ifdef SEQ_SHIFTER_LFSR_EN
    logic             lfsr_fb;
    logic             lfsr_in;
    logic [WIDTH-1:0] lfsr_next;

    assign lfsr_fb   = ^(q & TAPS & mask);
    // An all-zero active field would lock up, so seed it with a one.
    assign lfsr_in   = ((q & mask) == '0) ? 1'b1 : lfsr_fb;
    assign lfsr_next = (q & ~mask) | (((q << 1) | WIDTH'(lfsr_in)) & mask);
`endif

    always_comb begin
        q_next  = q;
        advance = 1'b0;
        case (mode)
            MODE_SHR: begin
                q_next  = {ser_in_r, q[WIDTH-1:1]};
                advance = 1'b1;
            end
            MODE_SHL: begin
                q_next  = {q[WIDTH-2:0], ser_in_l};
                advance = 1'b1;
            end
            MODE_ROTL: begin
                q_next  = (q & ~mask) | (((q << 1) | WIDTH'(ser_out)) & mask);
                advance = 1'b1;
            end
            MODE_ROTR: begin
                q_next  = (q & ~mask) | ((q & mask) >> 1) | (q[0] ? top_bit : '0);
                advance = 1'b1;
            end
`ifdef SEQ_SHIFTER_LFSR_EN
            MODE_LFSR: begin
                q_next  = lfsr_next;
                advance = 1'b1;
            end
`endif
            MODE_ASR: begin
                q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
                advance = 1'b1;
            end
            default: begin
                q_next  = q;
                advance = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= '0;
            len_r <= LEN_W'(WIDTH);
            cnt   <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (en) begin
                if (mode == MODE_LOAD) begin
                    q     <= load_data;
                    len_r <= len_load;
                    cnt   <= '0;
                end else if (advance) begin
                    q <= q_next;
                    if (cnt == len_r - LEN_W'(1)) begin
                        cnt  <= '0;
                        wrap <= 1'b1;
                    end else begin
                        cnt <= cnt + LEN_W'(1);
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_prog_seq_shifter.sv
// ============================================================================
// Module   : tb_prog_seq_shifter
// Purpose  : Directed self-checking bench for prog_seq_shifter (WIDTH=8).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prog_seq_shifter;
    import seq_shift_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic       ser_in_r;
    logic       ser_in_l;
    logic [7:0] load_data;
    logic [3:0] seq_len;
    logic [7:0] q;
    logic       ser_out;
    logic [3:0] cnt;
    logic       wrap;

    int errors = 0;
    int checks = 0;

    prog_seq_shifter dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .ser_in_r  (ser_in_r),
        .ser_in_l  (ser_in_l),
        .load_data (load_data),
        .seq_len   (seq_len),
        .q         (q),
        .ser_out   (ser_out),
        .cnt       (cnt),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] d, input logic [3:0] l);
        en        = 1'b1;
        mode      = MODE_LOAD;
        load_data = d;
        seq_len   = l;
        tick();
        mode = MODE_HOLD;
    endtask

    task automatic run(input logic [2:0] m, input int n);
        en   = 1'b1;
        mode = m;
        repeat (n) tick();
        mode = MODE_HOLD;
    endtask

    // 0x13 in a 6-bit field rotated left: MSB of the field before each step.
    logic [5:0] rot_seq = 6'b110010;
    logic       seen;

    initial begin
        rst = 1'b1; en = 1'b0; mode = MODE_HOLD;
        ser_in_r = 1'b0; ser_in_l = 1'b0; load_data = '0; seq_len = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset from an arbitrary state
        load(8'hA5, 4'd3);
        run(MODE_ROTL, 2);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_q", q, 8'h00);
        check("rst_cnt", cnt, 0);
        check("rst_wrap", wrap, 0);
        check("rst_ser", ser_out, 0);
        check("rst_len", dut.len_r, 8);

        // Rotate left within 6 bits, two full periods
        load(8'h13, 4'd6);
        check("ld_len6", dut.len_r, 6);
        check("ld_cnt", cnt, 0);
        en = 1'b1; mode = MODE_ROTL;
        for (int k = 0; k < 12; k++) begin
            check($sformatf("rotl_ser%0d", k), ser_out, rot_seq[k % 6]);
            tick();
            check($sformatf("rotl_wrap%0d", k), wrap, (k == 5 || k == 11));
        end
        mode = MODE_HOLD;
        check("rotl_q", q, 8'h13);
        check("rotl_cnt", cnt, 0);

        // Full-width shifts
        rst = 1'b1; tick(); rst = 1'b0;
        ser_in_r = 1'b1;
        run(MODE_SHR, 3);
        check("shr_q", q, 8'hE0);
        check("shr_cnt", cnt, 3);
        load(8'h00, 4'd8);
        ser_in_l = 1'b1;
        run(MODE_SHL, 4);
        check("shl_q", q, 8'h0F);
        check("shl_cnt", cnt, 4);
        load(8'h90, 4'd8);
        run(MODE_ASR, 1);
        check("asr_q", q, 8'hC8);

        // Partial-field rotates leave upper bits alone
        load(8'hC1, 4'd4);
        run(MODE_ROTR, 1);
        check("rotr4_q", q, 8'hC8);
        run(MODE_ROTL, 1);
        check("rotl4_q", q, 8'hC1);

        // LFSR from all-zero
        load(8'h00, 4'd8);
        run(MODE_LFSR, 1);
`ifdef SEQ_SHIFTER_LFSR_EN
        check("lfsr_q1", q, 8'h01);
`else
        check("lfsr_q1", q, 8'h00);
`endif
        run(MODE_LFSR, 1);
`ifdef SEQ_SHIFTER_LFSR_EN
        check("lfsr_q2", q, 8'h02);
        check("lfsr_cnt", cnt, 2);
`else
        check("lfsr_q2", q, 8'h00);
        check("lfsr_cnt", cnt, 0);
`endif

        // Length clamping
        load(8'h01, 4'd0);
        check("len0_clamp", dut.len_r, 8);
        load(8'h01, 4'd9);
        check("len9_clamp", dut.len_r, 8);

        // Length one: rotate is a no-op and wraps every advance
        load(8'hA5, 4'd1);
        en = 1'b1; mode = MODE_ROTL;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("len1_wrap%0d", k), wrap, 1);
        end
        mode = MODE_ROTR;
        tick();
        check("len1_rotr_wrap", wrap, 1);
        mode = MODE_HOLD;
        check("len1_q", q, 8'hA5);

        // Enable low freezes mid-rotate
        load(8'h13, 4'd6);
        run(MODE_ROTL, 2);
        check("pre_frz_q", q, 8'h0D);
        en = 1'b0; mode = MODE_ROTL;
        seen = 1'b0;
        repeat (3) begin
            tick();
            seen = seen | wrap;
        end
        check("frz_q", q, 8'h0D);
        check("frz_cnt", cnt, 2);
        check("frz_wrap", seen, 0);
        run(MODE_ROTR, 1);
        check("modechg_q", q, 8'h26);
        check("modechg_cnt", cnt, 3);

        // Reset mid-period abandons it
        load(8'h13, 4'd6);
        run(MODE_ROTL, 3);
        check("mid_cnt", cnt, 3);
        en = 1'b1; mode = MODE_ROTL; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_q", q, 8'h00);
        check("midrst_cnt", cnt, 0);
        check("midrst_wrap", wrap, 0);
        check("midrst_len", dut.len_r, 8);
        seen = 1'b0;
        repeat (7) begin
            tick();
            seen = seen | wrap;
        end
        check("midrst_nowrap", seen, 0);
        tick();
        check("midrst_wrap_full", wrap, 1);
        mode = MODE_HOLD;
        tick();
        check("wrap_pulse_end", wrap, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/prog_seq_shifter.md
PROG_SEQ_SHIFTER -- requirements
Module: prog_seq_shifter

Interface
REQ-001 Parameter WIDTH, default 8, register width (≥2).
REQ-002 Parameter LEN_W, default $clog2(WIDTH)+1, width of length/count fields.
REQ-003 Parameter TAPS, default 8'hB8 (WIDTH bits), LFSR feedback tap mask.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 en  in  1  advance enable; 0 = hold everything, no count.
REQ-007 mode  in  3  operation select (REQ-012).
REQ-008 ser_in_r / ser_in_l  in  1 each  fill bit for shift right / shift left.
REQ-009 load_data  in  WIDTH  parallel load value; seq_len  in  LEN_W  active length L, sampled on load.
REQ-010 q  out  WIDTH  register; ser_out  out  1  = q[len_r-1], combinational from registers.
REQ-011 cnt  out  LEN_W  position in period; wrap  out  1  registered one-cycle pulse.

Function
REQ-012 Modes (applied only when en=1): 000 hold; 001 shift right, MSB<=ser_in_r; 010 shift left, LSB<=ser_in_l; 011 load; 100 rotate left within q[L-1:0]; 101 rotate right within q[L-1:0]; 110 LFSR; 111 arithmetic right shift (MSB replicated).
REQ-013 Load: q<=load_data, len_r<=seq_len, cnt<=0, wrap<=0; seq_len=0 or >WIDTH clamps len_r to WIDTH.
REQ-014 Rotate/LFSR modes change only bits [len_r-1:0]; bits above held; shift modes 001/010/111 act on full WIDTH.
REQ-015 LFSR: fb = XOR of (q & TAPS) over bits [len_r-1:0]; q[len_r-1:0] <= {q[len_r-2:0], fb}.
REQ-016 LFSR lockup guard: if q[len_r-1:0]==0, injected bit is 1 instead of fb.
REQ-017 Advance = en=1 and mode ∉ {000,011}; each advance increments cnt.
REQ-018 Advance with cnt==len_r-1: cnt<=0, wrap<=1 next cycle; all other cycles wrap<=0.
REQ-019 len_r=1: rotate leaves q unchanged, wrap high every advanced cycle.
REQ-020 en=0: q, cnt, len_r hold; wrap<=0.
REQ-021 Mode change mid-period does not reset cnt; only load or reset does.

Reset
REQ-022 rst=1 at an edge dominates en/mode: q<=0, len_r<=WIDTH, cnt<=0, wrap<=0; hence ser_out=0.
REQ-023 Reset mid-period abandons the period; no wrap pulse generated.

Configuration
REQ-024 Macro SEQ_SHIFTER_LFSR_EN defined: mode 110 per REQ-015/016.
REQ-025 Macro undefined: no LFSR logic synthesised; mode 110 behaves as 000 (hold, no count).

Structure
REQ-026 Package seq_shift_pkg holds the 3-bit mode encodings as named constants, shared with benches.
REQ-027 One sub-module, seq_len_mask: converts len_r to a WIDTH-bit active mask used by rotate, LFSR and ser_out selection.

Verification (WIDTH=8, TAPS=8'hB8)
REQ-028 Reset: rst=1 one edge from arbitrary state -> q=8'h00, cnt=0, wrap=0, ser_out=0, len_r=8.
REQ-029 Load 8'h13, seq_len=6, then mode 100 en=1 for 12 cycles -> ser_out 0,1,0,0,1,1 repeated twice; wrap high after 6th and 12th advance; q=8'h13 at end.
REQ-030 From 8'h00: mode 001 ser_in_r=1 ×3 -> 8'hE0; from 8'h00 mode 010 ser_in_l=1 ×4 -> 8'h0F; 8'h90 mode 111 ×1 -> 8'hC8.
REQ-031 LFSR (macro on): load 8'h00 len 8, mode 110 ×2 -> 8'h01 then 8'h02; macro off same stimulus -> q stays 8'h00, cnt stays 0.
REQ-032 Boundaries: load seq_len=0 -> len_r=8; seq_len=1 rotate -> q unchanged, wrap every cycle; en=0 for 3 cycles mid-rotate -> q/cnt frozen, wrap low.
REQ-033 Reset mid-operation: rotate at cnt=3, assert rst -> next edge q=8'h00, cnt=0, wrap=0, no wrap pulse afterwards until a full period completes.
